hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage RV32I core. Decodes the IF/ID
//  instruction (opcodes 3/19/35/51/99, same classes ImmGen handles), keeps a
//  shadow of the ID/EX slot, and drives PC/IF-ID/ID-EX write, flush and bubble
//  enables for load-use stalls, taken-branch flushes, data-memory wait freezes
//  and post-reset pipeline fill.
// PARAMETERS
//  INIT_CYCLES  2   cycles of forced flush/bubble after reset release (>=1)
//  CNT_W        32  width of performance counters (PERF_CNT_EN only)
// PORTS
//  clk           in   1   core clock, all state on rising edge
//  reset         in   1   synchronous, active-high
//  if_id_inst    in   32  instruction currently in IF/ID register
//  ex_br_taken   in   1   branch in EX resolved taken (registered in EX, stable)
//  mem_busy      in   1   data memory not ready; whole pipe must hold
//  pc_write      out  1   1 = PC loads next value
//  if_id_write   out  1   1 = IF/ID register loads
//  if_id_flush   out  1   1 = IF/ID loads NOP (0x00000013) instead of fetch
//  id_ex_write   out  1   1 = ID/EX register loads
//  id_ex_bubble  out  1   1 = ID/EX loads all-zero control (bubble)
//  hz_state      out  2   FSM state: 0 INIT, 1 RUN, 2 FREEZE
//  stall_cnt     out  CNT_W  load-use stall cycles (PERF_CNT_EN only)
//  flush_cnt     out  CNT_W  branch flush events (PERF_CNT_EN only)
// BEHAVIOUR
//  - Decode: op=inst[6:0]; rs1 used for op 3,19,35,51,99; rs2 used for 35,51,99.
//    Unknown opcodes use neither. rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7].
//  - Shadow regs ex_load(1), ex_rd(5): on cycle where id_ex_write=1 they load
//    {op==3, rd}, or {0,0} if id_ex_bubble=1; otherwise hold.
//  - load_use = ex_load & ex_rd!=0 & ((use_rs1 & rs1==ex_rd)|(use_rs2 & rs2==ex_rd)).
//  - Outputs combinational from state+inputs. Priority (highest first):
//    reset/INIT: pc_write=0 if_id_write=1 if_id_flush=1 id_ex_write=1 id_ex_bubble=1
//    FREEZE (mem_busy=1): pc_write=0 if_id_write=0 id_ex_write=0 flush=0 bubble=0
//    branch (ex_br_taken): pc_write=1 if_id_write=1 if_id_flush=1 id_ex_write=1
//      id_ex_bubble=1 (2-cycle penalty; load_use ignored that cycle)
//    load_use: pc_write=0 if_id_write=0 id_ex_write=1 id_ex_bubble=1 (1 cycle; the
//      inserted bubble clears ex_load so stall never exceeds 1 cycle)
//    else: all writes 1, flush=0, bubble=0.
//  - FSM: reset -> INIT, init counter=INIT_CYCLES-1. INIT: count down, ->RUN at 0.
//    RUN: mem_busy -> FREEZE. FREEZE: mem_busy=0 -> RUN. mem_busy is ignored in INIT.
//    Output decision in FREEZE vs RUN evaluated on current-cycle mem_busy, so the
//    cycle mem_busy drops behaves as RUN (pending branch/load-use acted on then).
//  - ex_br_taken held during FREEZE is serviced on the first non-busy cycle, once.
//  - reset mid-operation: next cycle state=INIT, shadow cleared, counters zeroed.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stall_cnt +1 per cycle load_use action taken,
//    flush_cnt +1 per cycle branch action taken; wrap at 2^CNT_W; 0 on reset.
//  Undefined: stall_cnt/flush_cnt ports absent, no counter logic.
// TESTING
//  1 reset 3 cycles, release -> INIT 2 cycles: flush=1 bubble=1 pc_write=0; then
//    hz_state=1, all writes 1.
//  2 lw x5,0(x1) 0x0000A283 then add x6,x5,x2 0x00228333 -> exactly 1 cycle
//    pc_write=0 if_id_write=0 id_ex_bubble=1; stall_cnt=1; add proceeds next cycle.
//  3 lw x0,0(x1) 0x0000A003 then add x6,x0,x2 -> no stall (rd=0 exempt);
//    lw x5 then sw x5,0(x1) 0x0050A023 -> 1-cycle stall (rs2 match).
//  4 lw x5 in EX, add x6,x5,x2 in ID, ex_br_taken=1 same cycle -> branch wins:
//    if_id_flush=1 bubble=1 pc_write=1, no stall; flush_cnt=1, stall_cnt=0.
//  5 mem_busy=1 for 4 cycles with ex_br_taken=1 -> hz_state=2, all writes 0 for 4
//    cycles; on 5th cycle single flush, flush_cnt increments by exactly 1.
//  6 reset asserted during load-use stall -> next cycle INIT, shadow cleared, counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush, memory freeze, post-reset fill.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int INIT_CYCLES = 2
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_id_inst,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic [1:0]       hz_state
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ACT_INIT,
    ACT_FREEZE,
    ACT_BRANCH,
    ACT_STALL,
    ACT_RUN
  } act_e;

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_BRANCH = 7'd99;

  state_e         state_q, state_d;
  logic [ICW-1:0] init_cnt_q, init_cnt_d;
  logic           ex_load_q, ex_load_d;
  logic [4:0]     ex_rd_q, ex_rd_d;
  act_e           act;

  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;
  logic       use_rs1, use_rs2, load_use;
  logic       unused_inst_bits;

  assign op  = if_id_inst[6:0];
  assign rd  = if_id_inst[11:7];
  assign rs1 = if_id_inst[19:15];
  assign rs2 = if_id_inst[24:20];
  assign unused_inst_bits = ^{if_id_inst[31:25], if_id_inst[14:12]};

  assign use_rs1 = (op == OP_LOAD) || (op == OP_IMM) || (op == OP_STORE) ||
                   (op == OP_REG)  || (op == OP_BRANCH);
  assign use_rs2 = (op == OP_STORE) || (op == OP_REG) || (op == OP_BRANCH);

  assign load_use = ex_load_q && (ex_rd_q != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_rd_q)) || (use_rs2 && (rs2 == ex_rd_q)));

  // Freeze follows the live mem_busy so the cycle it drops already acts as RUN.
  always_comb begin
    act = ACT_RUN;
    if (reset || (state_q == ST_INIT)) act = ACT_INIT;
    else if (mem_busy)                 act = ACT_FREEZE;
    else if (ex_br_taken)              act = ACT_BRANCH;
    else if (load_use)                 act = ACT_STALL;
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    case (act)
      ACT_INIT: begin
        pc_write     = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      ACT_FREEZE: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
      end
      ACT_BRANCH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      ACT_STALL: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == '0) state_d = ST_RUN;
        else                  init_cnt_d = init_cnt_q - 1'b1;
      end
      ST_RUN:    if (mem_busy)  state_d = ST_FREEZE;
      ST_FREEZE: if (!mem_busy) state_d = ST_RUN;
      default:   state_d = ST_INIT;
    endcase
  end

  // Shadow of the ID/EX slot: a bubble clears it, which bounds a stall to one cycle.
  always_comb begin
    ex_load_d = ex_load_q;
    ex_rd_d   = ex_rd_q;
    if (id_ex_write) begin
      if (id_ex_bubble) begin
        ex_load_d = 1'b0;
        ex_rd_d   = 5'd0;
      end else begin
        ex_load_d = (op == OP_LOAD);
        ex_rd_d   = rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= INIT_LAST;
      ex_load_q  <= 1'b0;
      ex_rd_q    <= 5'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ex_load_q  <= ex_load_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  assign hz_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (act == ACT_STALL)  stall_cnt_d = stall_cnt_q + 1'b1;
    if (act == ACT_BRANCH) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios followed by random traffic,
// each cycle checked against a rule-level model of the controller.
module tb_hazard_ctrl;

  localparam int INIT_CYCLES = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Action classes and the control tuple each one requires:
  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble}
  localparam int A_INIT = 0, A_FREEZE = 1, A_BRANCH = 2, A_STALL = 3, A_RUN = 4;
  logic [4:0] act_tbl [5];

  logic        clk;
  logic        reset;
  logic [31:0] if_id_inst;
  logic        ex_br_taken;
  logic        mem_busy;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic [1:0]  hz_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_id_inst   (if_id_inst),
    .ex_br_taken  (ex_br_taken),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_write  (id_ex_write),
    .id_ex_bubble (id_ex_bubble),
    .hz_state     (hz_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt  (stall_cnt)
    , .flush_cnt  (flush_cnt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state and scoreboard
  int          m_state;     // 0 INIT, 1 RUN, 2 FREEZE
  int          m_init_left;
  bit          m_ex_load;
  int          m_ex_rd;
  int unsigned m_stall, m_flush;
  logic [6:0]  exp_q [$];
  int          n_vec, n_err;

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
    logic [31:0] w;
    w = '0;
    w[6:0]   = op[6:0];
    w[11:7]  = rd[4:0];
    w[19:15] = rs1[4:0];
    w[24:20] = rs2[4:0];
    return w;
  endfunction

  task automatic model_reset();
    m_state = 0; m_init_left = INIT_CYCLES - 1;
    m_ex_load = 0; m_ex_rd = 0; m_stall = 0; m_flush = 0;
  endtask

  // One clock: drive, check mid-cycle, then advance the model across the edge.
  task automatic step(input logic [31:0] inst, input bit br, input bit busy, input bit rst);
    int op, rs1, rs2, rd, act;
    bit u1, u2, hazard;
    logic [6:0] obs, exp_v;
    reset = rst; if_id_inst = inst; ex_br_taken = br; mem_busy = busy;
    op = int'(inst[6:0]); rd = int'(inst[11:7]);
    rs1 = int'(inst[19:15]); rs2 = int'(inst[24:20]);
    u1 = (op == 3) || (op == 19) || (op == 35) || (op == 51) || (op == 99);
    u2 = (op == 35) || (op == 51) || (op == 99);
    hazard = m_ex_load && (m_ex_rd != 0) && ((u1 && rs1 == m_ex_rd) || (u2 && rs2 == m_ex_rd));
    if (rst || m_state == 0) act = A_INIT;
    else if (busy)           act = A_FREEZE;
    else if (br)             act = A_BRANCH;
    else if (hazard)         act = A_STALL;
    else                     act = A_RUN;
    exp_q.push_back({act_tbl[act], 2'(m_state)});

    @(negedge clk);
    obs   = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, hz_state};
    exp_v = exp_q.pop_front();
    n_vec++;
    assert (obs[6:2] === exp_v[6:2]) else begin
      n_err++;
      $error("FAIL ctrl t=%0t inst=%h br=%0b busy=%0b rst=%0b observed=%b expected=%b",
             $time, inst, br, busy, rst, obs[6:2], exp_v[6:2]);
    end
    n_vec++;
    assert (obs[1:0] === exp_v[1:0]) else begin
      n_err++;
      $error("FAIL hz_state t=%0t observed=%0d expected=%0d", $time, obs[1:0], exp_v[1:0]);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    assert (stall_cnt === m_stall) else begin
      n_err++;
      $error("FAIL stall_cnt t=%0t observed=%0d expected=%0d", $time, stall_cnt, m_stall);
    end
    n_vec++;
    assert (flush_cnt === m_flush) else begin
      n_err++;
      $error("FAIL flush_cnt t=%0t observed=%0d expected=%0d", $time, flush_cnt, m_flush);
    end
`endif

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (act != A_FREEZE) begin
        if (act == A_RUN) begin m_ex_load = (op == 3); m_ex_rd = rd; end
        else              begin m_ex_load = 0;         m_ex_rd = 0;  end
      end
      if (act == A_STALL)  m_stall++;
      if (act == A_BRANCH) m_flush++;
      if (m_state == 0)      m_state = (m_init_left == 0) ? 1 : 0;
      else if (m_state == 1) m_state = busy ? 2 : 1;
      else                   m_state = busy ? 2 : 1;
      if (m_state == 0) m_init_left--;
    end
    #1;
  endtask

  localparam logic [31:0] LW_X5  = 32'h0000_A283;
  localparam logic [31:0] ADD_5  = 32'h0022_8333;
  localparam logic [31:0] LW_X0  = 32'h0000_A003;
  localparam logic [31:0] ADD_0  = 32'h0020_0333;
  localparam logic [31:0] SW_X5  = 32'h0050_A023;

  initial begin
    int ops [7];
    bit busy_run;
    act_tbl[A_INIT]   = 5'b01111;
    act_tbl[A_FREEZE] = 5'b00000;
    act_tbl[A_BRANCH] = 5'b11111;
    act_tbl[A_STALL]  = 5'b00011;
    act_tbl[A_RUN]    = 5'b11010;
    ops = '{3, 19, 35, 51, 99, 55, 111};
    n_vec = 0; n_err = 0;

    reset = 1'b1; if_id_inst = NOP; ex_br_taken = 1'b0; mem_busy = 1'b0;
    @(posedge clk); #1;
    model_reset();

    // Reset held, then INIT fill, then RUN
    repeat (3) step(NOP, 0, 0, 1);
    repeat (INIT_CYCLES) step(NOP, 0, 1, 0);
    step(NOP, 0, 0, 0);

    // Load-use on rs1, then add proceeds
    step(LW_X5, 0, 0, 0); step(ADD_5, 0, 0, 0); step(ADD_5, 0, 0, 0); step(NOP, 0, 0, 0);
    // rd = x0 exempt, then rs2 match through a store
    step(LW_X0, 0, 0, 0); step(ADD_0, 0, 0, 0);
    step(LW_X5, 0, 0, 0); step(SW_X5, 0, 0, 0); step(SW_X5, 0, 0, 0); step(NOP, 0, 0, 0);
    // Branch beats load-use
    step(LW_X5, 0, 0, 0); step(ADD_5, 1, 0, 0); step(NOP, 0, 0, 0); step(NOP, 0, 0, 0);
    // Memory freeze with a pending branch, serviced once afterwards
    repeat (4) step(ADD_5, 1, 1, 0);
    step(ADD_5, 1, 0, 0); step(NOP, 0, 0, 0);
    // Reset in the middle of a load-use stall
    step(LW_X5, 0, 0, 0); step(ADD_5, 0, 0, 1); step(ADD_5, 0, 0, 0);
    repeat (INIT_CYCLES) step(NOP, 0, 0, 0);

    // Random traffic with a small register pool to provoke hazards
    busy_run = 0;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] inst;
      inst = mk(ops[$urandom_range(0, 6)], $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      if (busy_run) busy_run = ($urandom_range(0, 2) != 0);
      else          busy_run = ($urandom_range(0, 7) == 0);
      step(inst, ($urandom_range(0, 5) == 0), busy_run, ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
